epd_frame_detector: RTL and testbench

//  Parametrised Ethernet packet detector; successor to the fixed-size EPD FSM.

---
 rtl/epd_frame_detector_pkg.sv | 33 +++
 rtl/epd_frame_detector_if.sv | 11 +
 rtl/epd_frame_detector_byte_counter.sv | 38 +++
 rtl/epd_frame_detector.sv | 239 +++++++++++++++++++++++
 tb/tb_epd_frame_detector.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/epd_frame_detector_pkg.sv
// Package epd_pkg: shared state encoding and field constants for the EPD frame detector.
//   epd_state_e    - 8-state frame walker encoding
//   PREAMBLE_BYTE  - preamble octet (8'h55)
//   SFD_BYTE       - start-of-frame delimiter (8'hD5)
//   BCAST_ADDR     - broadcast destination address
//   MAX_LEN_FIELD  - largest legal length value (1500)
//   MIN_TYPE_FIELD - smallest legal EtherType value (1536)
//   type_len_ok()  - legality check for the 16-bit type/length field
package epd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StDst,
    StSrc,
    StType,
    StPayload,
    StDrop
  } epd_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [47:0] BCAST_ADDR     = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] MAX_LEN_FIELD  = 16'd1500;
  localparam logic [15:0] MIN_TYPE_FIELD = 16'd1536;

  // Values 1501..1535 are neither a length nor an EtherType.
  function automatic logic type_len_ok(input logic [15:0] v);
    return (v <= MAX_LEN_FIELD) || (v >= MIN_TYPE_FIELD);
  endfunction

endpackage

// File: rtl/epd_frame_detector_if.sv
// Byte-wide receive bus feeding the EPD frame detector.
//   data    - receive byte, valid while control=1
//   control - 1 = byte of current frame present; falling edge marks frame end
// Modports: master drives the bus (PHY side / bench), slave samples it (detector).
interface epd_frame_detector_if;
  logic [7:0] data;
  logic       control;

  modport master (output data, output control);
  modport slave  (input data, input control);
endinterface

// File: rtl/epd_frame_detector_byte_counter.sv
// epd_byte_counter: saturating up-counter with synchronous clear.
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   clr_i  - clear; when asserted with inc_i the count restarts at 1
//   inc_i  - increment, holds at MaxVal
//   cnt_o  - current count
module epd_byte_counter #(
  parameter int unsigned Width  = 4,
  parameter int unsigned MaxVal = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d, base;

  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (inc_i && (base != Width'(MaxVal))) begin
      cnt_d = base + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/epd_frame_detector.sv
// epd_frame_detector: walks a byte-wide Ethernet receive stream (preamble+SFD, dst, src,
// type/length, payload), raises sticky per-field flags, pulses packet_size_valid at frame end
// when the dst..FCS size is in [MIN_PKT, MAX_PKT], and counts fully valid frames.
// Ports:
//   clock, reset         - single clock, synchronous active-high reset
//   rx (slave)           - data[7:0] / control receive bus
//   preamble_valid       - preamble+SFD seen (sticky)
//   dst_addr_valid       - 6 dst bytes accepted (sticky)
//   src_addr_valid       - 6 src bytes, unicast (sticky)
//   type_length_valid    - legal type/length field (sticky)
//   packet_size_valid    - one-cycle pulse after a frame ending in PAYLOAD with legal size
//   valid_packet_counter - wrapping count of fully valid frames
// Build option: define EPD_ADDR_FILTER_EN to accept only dst == MAC_ADDR or broadcast.
module epd_frame_detector
  import epd_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_PKT      = 64,
  parameter int unsigned MAX_PKT      = 1518,
  parameter int unsigned CNT_W        = 4,
  parameter logic [47:0] MAC_ADDR     = 48'h0000_0000_0001
) (
  input  logic             clock,
  input  logic             reset,
  epd_frame_detector_if.slave rx,
  output logic             preamble_valid,
  output logic             dst_addr_valid,
  output logic             src_addr_valid,
  output logic             type_length_valid,
  output logic             packet_size_valid,
  output logic [CNT_W-1:0] valid_packet_counter
);

  // One index counter serves both the preamble run and the per-field byte index.
  localparam int unsigned IdxMax  = (PREAMBLE_LEN > 6) ? PREAMBLE_LEN : 6;
  localparam int unsigned IdxW    = $clog2(IdxMax + 1);
  localparam int unsigned SizeMax = MAX_PKT + 1;
  localparam int unsigned SizeW   = $clog2(SizeMax + 1);

  epd_state_e       state_q, state_d;
  logic             pre_q, pre_d, dst_q, dst_d, src_q, src_d, type_q, type_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       type_hi_q, type_hi_d;

  logic [IdxW-1:0]  idx_cnt;
  logic [SizeW-1:0] size_cnt;
  logic             idx_clr, idx_inc, size_clr, size_inc;
  logic             size_ok, dst_ok;

`ifdef EPD_ADDR_FILTER_EN
  logic [47:0] dst_sr_q, dst_sr_d;
  logic [47:0] dst_full;
  assign dst_full = {dst_sr_q[39:0], rx.data};
  assign dst_ok   = (dst_full == MAC_ADDR) || (dst_full == BCAST_ADDR);
`else
  logic unused_mac;
  assign unused_mac = ^MAC_ADDR;
  assign dst_ok     = 1'b1;
`endif

  // Size counts dst..last byte; idle cycles guarantee it starts each frame at zero.
  assign size_clr = (state_q == StIdle);
  assign size_inc = rx.control && (state_q inside {StDst, StSrc, StType, StPayload});
  assign size_ok  = (size_cnt >= SizeW'(MIN_PKT)) && (size_cnt <= SizeW'(MAX_PKT));

  epd_byte_counter #(.Width(IdxW), .MaxVal(IdxMax)) u_idx_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (idx_clr),
    .inc_i (idx_inc),
    .cnt_o (idx_cnt)
  );

  epd_byte_counter #(.Width(SizeW), .MaxVal(SizeMax)) u_size_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (size_clr),
    .inc_i (size_inc),
    .cnt_o (size_cnt)
  );

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    dst_d     = dst_q;
    src_d     = src_q;
    type_d    = type_q;
    pulse_d   = 1'b0;
    count_d   = count_q;
    type_hi_d = type_hi_q;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
`ifdef EPD_ADDR_FILTER_EN
    dst_sr_d  = dst_sr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx.control) begin
          if (rx.data == PREAMBLE_BYTE) begin
            idx_clr = 1'b1;
            idx_inc = 1'b1;
            state_d = (PREAMBLE_LEN == 1) ? StSfd : StPreamble;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPreamble: begin
        if (!rx.control) begin
          state_d = StIdle;
        end else if (rx.data != PREAMBLE_BYTE) begin
          state_d = StDrop;
        end else begin
          idx_inc = 1'b1;
          if (idx_cnt == IdxW'(PREAMBLE_LEN - 1)) state_d = StSfd;
        end
      end
      StSfd: begin
        if (!rx.control) begin
          state_d = StIdle;
        end else if (rx.data == SFD_BYTE) begin
          pre_d   = 1'b1;
          idx_clr = 1'b1;
          state_d = StDst;
        end else begin
          state_d = StDrop;
        end
      end
      StDst: begin
        if (!rx.control) begin
          state_d = StIdle;
        end else begin
`ifdef EPD_ADDR_FILTER_EN
          dst_sr_d = dst_full;
`endif
          idx_inc = 1'b1;
          if (idx_cnt == IdxW'(5)) begin
            idx_clr = 1'b1;
            idx_inc = 1'b0;
            if (dst_ok) begin
              dst_d   = 1'b1;
              state_d = StSrc;
            end else begin
              state_d = StDrop;
            end
          end
        end
      end
      StSrc: begin
        if (!rx.control) begin
          state_d = StIdle;
        end else if ((idx_cnt == '0) && rx.data[0]) begin
          // Group bit set in the first src byte: multicast source is illegal.
          state_d = StDrop;
        end else begin
          idx_inc = 1'b1;
          if (idx_cnt == IdxW'(5)) begin
            idx_clr = 1'b1;
            idx_inc = 1'b0;
            src_d   = 1'b1;
            state_d = StType;
          end
        end
      end
      StType: begin
        if (!rx.control) begin
          state_d = StIdle;
        end else if (idx_cnt == '0) begin
          type_hi_d = rx.data;
          idx_inc   = 1'b1;
        end else begin
          idx_clr = 1'b1;
          if (type_len_ok({type_hi_q, rx.data})) begin
            type_d  = 1'b1;
            state_d = StPayload;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPayload: begin
        if (!rx.control) begin
          pulse_d = size_ok;
          if (size_ok && pre_q && dst_q && src_q && type_q) count_d = count_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (!rx.control) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flags are per-frame: they vanish when the frame is finished or rejected.
    if ((state_d == StIdle) || (state_d == StDrop)) begin
      pre_d  = 1'b0;
      dst_d  = 1'b0;
      src_d  = 1'b0;
      type_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pre_q     <= 1'b0;
      dst_q     <= 1'b0;
      src_q     <= 1'b0;
      type_q    <= 1'b0;
      pulse_q   <= 1'b0;
      count_q   <= '0;
      type_hi_q <= '0;
`ifdef EPD_ADDR_FILTER_EN
      dst_sr_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      type_q    <= type_d;
      pulse_q   <= pulse_d;
      count_q   <= count_d;
      type_hi_q <= type_hi_d;
`ifdef EPD_ADDR_FILTER_EN
      dst_sr_q  <= dst_sr_d;
`endif
    end
  end

  assign preamble_valid       = pre_q;
  assign dst_addr_valid       = dst_q;
  assign src_addr_valid       = src_q;
  assign type_length_valid    = type_q;
  assign packet_size_valid    = pulse_q;
  assign valid_packet_counter = count_q;

endmodule

// File: tb/tb_epd_frame_detector.sv
// Bench for epd_frame_detector: directed frames with a frame-level model that derives, from
// byte positions and field rules, the expected outputs after every sampled byte.
// Honours EPD_ADDR_FILTER_EN when the same macro is defined for the build.
module tb_epd_frame_detector;

  localparam int unsigned PreLen  = 7;
  localparam int unsigned MinPkt  = 64;
  localparam int unsigned MaxPkt  = 1518;
  localparam int unsigned CntW    = 4;
  localparam logic [47:0] MacAddr = 48'h0000_0000_0001;
  localparam int          S       = PreLen + 1;  // index of first dst byte
`ifdef EPD_ADDR_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  typedef logic [7:0] bytes_t[$];

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid;
  logic            packet_size_valid;
  logic [CntW-1:0] valid_packet_counter;
  logic [CntW-1:0] exp_cnt = '0;
  int              n_tests = 0;
  int              n_fail  = 0;
  logic            dut_pulse;

  epd_frame_detector_if rx ();

  epd_frame_detector #(
    .PREAMBLE_LEN (PreLen),
    .MIN_PKT      (MinPkt),
    .MAX_PKT      (MaxPkt),
    .CNT_W        (CntW),
    .MAC_ADDR     (MacAddr)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .rx                   (rx),
    .preamble_valid       (preamble_valid),
    .dst_addr_valid       (dst_addr_valid),
    .src_addr_valid       (src_addr_valid),
    .type_length_valid    (type_length_valid),
    .packet_size_valid    (packet_size_valid),
    .valid_packet_counter (valid_packet_counter)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, then compare {pre,dst,src,type,pulse,counter} just after the edge.
  task automatic step(input logic ctl, input logic [7:0] d, input logic [3:0] flags,
                      input logic pulse);
    @(negedge clock);
    rx.control = ctl;
    rx.data    = d;
    @(posedge clock);
    #1;
    check("outputs", {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
                      packet_size_valid, valid_packet_counter},
          {flags, pulse, exp_cnt});
  endtask

  task automatic do_reset(input logic ctl);
    @(negedge clock);
    reset      = 1'b1;
    rx.control = ctl;
    rx.data    = 8'h55;
    @(posedge clock);
    #1;
    exp_cnt = '0;
    check("reset_state", {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
                          packet_size_valid, valid_packet_counter}, 32'd0);
    @(negedge clock);
    reset      = 1'b0;
    rx.control = 1'b0;
  endtask

  function automatic bytes_t make_frame(input logic [47:0] dst, input logic [7:0] src0,
                                        input logic [15:0] tl, input int body);
    bytes_t f;
    for (int i = 0; i < int'(PreLen); i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) f.push_back(dst[i*8 +: 8]);
    f.push_back(src0);
    for (int i = 0; i < 4; i++) f.push_back(8'h00);
    f.push_back(8'h01);
    f.push_back(tl[15:8]);
    f.push_back(tl[7:0]);
    for (int i = 0; i < body; i++) f.push_back(8'(i * 7 + 3));
    return f;
  endfunction

  // Frame-level model: locate the first rule violation, then flag k is up after byte i iff
  // the field has completed by i and nothing has failed yet.
  task automatic send_frame(input bytes_t f);
    int          l = f.size();
    int          drop_at = -1;
    logic [47:0] da = '0;
    int          tl;
    int          size;
    logic        pulse;
    logic [3:0]  flags;
    for (int i = 0; i < l; i++) begin
      if (i >= S && i < S + 6) da = {da[39:0], f[i]};
      if (drop_at < 0) begin
        if (i < int'(PreLen) && f[i] != 8'h55) drop_at = i;
        if (i == int'(PreLen) && f[i] != 8'hD5) drop_at = i;
        if (FilterEn && i == S + 5 && da != MacAddr && da != 48'hFFFF_FFFF_FFFF) drop_at = i;
        if (i == S + 6 && f[i][0]) drop_at = i;
        if (i == S + 13) begin
          tl = {f[S+12], f[i]};
          if (tl > 1500 && tl < 1536) drop_at = i;
        end
      end
      if (drop_at >= 0) flags = 4'b0000;
      else flags = {i >= int'(PreLen), i >= S + 5, i >= S + 11, i >= S + 13};
      step(1'b1, f[i], flags, 1'b0);
    end
    size  = l - S;
    pulse = (drop_at < 0) && (l >= S + 14) && (size >= int'(MinPkt)) && (size <= int'(MaxPkt));
    if (pulse) exp_cnt = exp_cnt + 1'b1;
    step(1'b0, 8'h00, 4'b0000, pulse);
    dut_pulse = packet_size_valid;
    step(1'b0, 8'h00, 4'b0000, 1'b0);
  endtask

  initial begin
    bytes_t fr;
    rx.control = 1'b0;
    rx.data    = 8'h00;
    repeat (2) @(posedge clock);
    do_reset(1'b1);

    // 64-byte frame: everything valid.
    send_frame(make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h0800, 50));
    check("t1_pulse", 32'(dut_pulse), 32'd1);
    check("t1_count", 32'(valid_packet_counter), 32'd1);

    // 63 bytes: fields fine, size too small.
    send_frame(make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h0800, 49));
    check("t2_pulse", 32'(dut_pulse), 32'd0);
    check("t2_count", 32'(valid_packet_counter), 32'd1);

    // Third preamble byte corrupted.
    fr = make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h0800, 50);
    fr[2] = 8'h54;
    send_frame(fr);
    check("t3_count", 32'(valid_packet_counter), 32'd1);

    // SFD arriving one byte early.
    fr = make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h0800, 50);
    fr[6] = 8'hD5;
    send_frame(fr);

    // Abort after the third src byte.
    fr = make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h0800, 50);
    while (fr.size() > S + 9) void'(fr.pop_back());
    send_frame(fr);
    check("t4_count", 32'(valid_packet_counter), 32'd1);

    // Type/length boundaries.
    send_frame(make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h05DD, 50));
    check("t5_type1501_count", 32'(valid_packet_counter), 32'd1);
    send_frame(make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h05DC, 50));
    check("t5_type1500_count", 32'(valid_packet_counter), 32'd2);
    send_frame(make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h0600, 50));
    check("t5_type1536_count", 32'(valid_packet_counter), 32'd3);
    send_frame(make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h05FF, 50));

    // Size upper boundary: 1518 counts, 1519 does not.
    send_frame(make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h0800, 1504));
    check("t5_1518_pulse", 32'(dut_pulse), 32'd1);
    send_frame(make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h0800, 1505));
    check("t5_1519_pulse", 32'(dut_pulse), 32'd0);

    // Multicast source.
    send_frame(make_frame(48'hFFFF_FFFF_FFFF, 8'h03, 16'h0800, 50));
    check("src_mcast_count", 32'(valid_packet_counter), 32'd4);

    // Destination filtering (rejected only when the filter is built in).
    send_frame(make_frame(MacAddr + 48'd1, 8'h02, 16'h0800, 50));
    send_frame(make_frame(MacAddr, 8'h02, 16'h0800, 50));

    // Reset mid-frame dominates a present byte and clears the counter.
    fr = make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h0800, 50);
    for (int i = 0; i < 12; i++) step(1'b1, fr[i], {i >= int'(PreLen), 3'b000}, 1'b0);
    do_reset(1'b1);
    step(1'b0, 8'h00, 4'b0000, 1'b0);

    // Counter wrap after 16 valid frames.
    for (int k = 1; k <= 16; k++) begin
      send_frame(make_frame(48'hFFFF_FFFF_FFFF, 8'h02, 16'h0800, 50));
      if (k == 15) check("wrap_15", 32'(valid_packet_counter), 32'd15);
      if (k == 16) check("wrap_0", 32'(valid_packet_counter), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
